cnn_layer_scheduler: RTL and testbench
======================================

// Module: cnn_layer_scheduler
// PURPOSE
//  Frame-level sequencer for the CNN inference chain: conv1, pool1, conv2, pool2, conv3, pool3, dense0, dense1.
//  Accepts one frame per handshake and fires each stage's one-cycle start pulse in order.
//  Waits for that stage's done before moving on, then presents a result handshake downstream.
//  Guards every stage with a watchdog timer so a hung layer is reported rather than silently stalling.
// PARAMETERS
//  N_STAGES   8        number of sequenced stages; stage index 0 runs first
//  IDX_W      3        width of stage index, >= clog2(N_STAGES)
//  TIMEOUT_W  20       width of watchdog counter and of the TIMEOUT parameter
//  TIMEOUT    1000000  max cycles in WAIT per stage; 0 disables the watchdog
//  CNT_W      16       width of completed-frame counter
// PORTS
//  clk             in   1          clock, all logic on rising edge
//  reset           in   1          synchronous, active-high reset
//  frame_valid_i   in   1          input frame available (held until accepted)
//  frame_ready_o   out  1          scheduler idle, can accept a frame
//  stage_start_o   out  N_STAGES   one-hot start pulse, bit k starts stage k
//  stage_done_i    in   N_STAGES   bit k = stage k done (pulse or level)
//  result_valid_o  out  1          final stage finished, result available
//  result_ready_i  in   1          downstream consumes result
//  busy_o          out  1          frame in flight (START/WAIT/OUT)
//  cur_stage_o     out  IDX_W      index of active stage; 0 when idle
//  err_timeout_o   out  1          watchdog tripped; sticky until clear_err_i
//  err_stage_o     out  IDX_W      stage index that timed out
//  clear_err_i     in   1          leave ERR state
//  frame_cnt_o     out  CNT_W      completed frames, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Outputs are registered or pure decodes of registered state; no input-to-output combinational path.
//  Reset, when sampled high:
//   - state forced to IDLE; stage, timer, frame_cnt_o, err_stage_o forced to 0.
//   - every output reads 0 in the cycle after; frame_ready_o rises in the first cycle after reset is low.
//   - reset mid-frame abandons the frame; no start pulse and no result are issued for it.
//  IDLE:
//   - frame_ready_o=1.
//   - frame_valid_i & frame_ready_o -> START with stage=0.
//  START:
//   - stage_start_o[stage]=1 for exactly one cycle; timer cleared -> WAIT.
//   - stage_done_i is not sampled in START.
//  WAIT:
//   - stage_start_o=0; timer increments each cycle.
//   - stage_done_i[stage]=1 and stage<N_STAGES-1 -> stage+1, START.
//   - stage_done_i[stage]=1 and stage==N_STAGES-1 -> OUT.
//   - done bits of other stages are ignored.
//   - TIMEOUT!=0 and timer==TIMEOUT-1 without done -> ERR, err_stage_o=stage.
//   - done arriving in the same cycle as expiry wins; no error is raised.
//  OUT:
//   - result_valid_o=1, held until result_ready_i=1.
//   - on handshake: frame_cnt_o+1 (wrap) -> IDLE.
//   - result_ready_i while not in OUT is ignored.
//  ERR:
//   - err_timeout_o=1, busy_o=0, frame_ready_o=0.
//   - clear_err_i -> IDLE; err_stage_o keeps its value until the next error or reset.
//  Latency:
//   - accept at cycle T -> stage_start_o[0] at T+1.
//   - done of stage k at cycle D -> start of stage k+1 at D+1 (last stage: result_valid_o at D+1).
//   - result handshake at R -> frame_ready_o at R+1.
//   - a frame with instant dones takes 2*N_STAGES+1 cycles from accept to result_valid_o.
//  Back-to-back frames: a new frame is accepted only after the result handshake; one frame in flight at a time.
//  cur_stage_o = stage register in START/WAIT, N_STAGES-1 in OUT, 0 otherwise.
// TESTING
//  1. Reset held 3 cycles, then released:
//     -> all outputs 0 during reset; frame_ready_o=1 one cycle after release; frame_cnt_o=0.
//  2. One frame; each done_i[k] pulsed 5 cycles after start_o[k]; result_ready_i=1:
//     -> exactly 8 one-hot start pulses in order 0..7; result_valid_o for 1 cycle; frame_cnt_o=1.
//  3. done_i[3] pulsed while in WAIT on stage 1, result_ready_i low 10 cycles:
//     -> done_i[3] ignored; result_valid_o held 10 cycles; no frame accepted meanwhile.
//  4. TIMEOUT=16, stage 2 never completes:
//     -> ERR entered 16 cycles after start_o[2]; err_timeout_o=1, err_stage_o=2.
//     -> clear_err_i then frame_ready_o=1 next cycle.
//  5. TIMEOUT=16, done_i[2] asserted exactly at the expiry cycle:
//     -> no error; start_o[3] next cycle.
//  6. Reset pulsed during stage 5 WAIT, then a new frame:
//     -> no stage 6 start; the new frame restarts at stage 0.
//     -> CNT_W=2, 5 frames: frame_cnt_o wraps to 1.

Source files
------------

// File: rtl/cnn_layer_scheduler.sv
// Frame-level sequencer for the CNN inference chain: starts each stage in turn, waits for
// its done, then hands the result downstream. A per-stage watchdog flags hung layers.
module cnn_layer_scheduler #(
  parameter int unsigned N_STAGES  = 8,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned TIMEOUT_W = 20,
  parameter int unsigned TIMEOUT   = 1000000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_valid_i,
  output logic                frame_ready_o,
  output logic [N_STAGES-1:0] stage_start_o,
  input  logic [N_STAGES-1:0] stage_done_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic                busy_o,
  output logic [IDX_W-1:0]    cur_stage_o,
  output logic                err_timeout_o,
  output logic [IDX_W-1:0]    err_stage_o,
  input  logic                clear_err_i,
  output logic [CNT_W-1:0]    frame_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_OUT,
    S_ERR
  } state_t;

  localparam logic [IDX_W-1:0]     LAST_STAGE = IDX_W'(N_STAGES - 1);
  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT - 1);
  localparam bit                   WDOG_EN    = (TIMEOUT != 0);

  state_t               state;
  logic [IDX_W-1:0]     stage;
  logic [TIMEOUT_W-1:0] timer;
  // Low in the cycle after reset so frame_ready stays 0 until reset has been released.
  logic                 live;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      stage       <= '0;
      timer       <= '0;
      frame_cnt_o <= '0;
      err_stage_o <= '0;
      live        <= 1'b0;
    end else begin
      live <= 1'b1;
      case (state)
        S_IDLE: begin
          if (frame_valid_i && live) begin
            stage <= '0;
            state <= S_START;
          end
        end
        S_START: begin
          timer <= '0;
          state <= S_WAIT;
        end
        // A done in the expiry cycle takes priority over the watchdog.
        S_WAIT: begin
          if (stage_done_i[stage]) begin
            if (stage == LAST_STAGE) begin
              state <= S_OUT;
            end else begin
              stage <= stage + IDX_W'(1);
              state <= S_START;
            end
          end else if (WDOG_EN && (timer == TIMER_LAST)) begin
            err_stage_o <= stage;
            state       <= S_ERR;
          end else begin
            timer <= timer + TIMEOUT_W'(1);
          end
        end
        S_OUT: begin
          if (result_ready_i) begin
            frame_cnt_o <= frame_cnt_o + CNT_W'(1);
            state       <= S_IDLE;
          end
        end
        S_ERR: begin
          if (clear_err_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign frame_ready_o  = (state == S_IDLE) && live;
  assign stage_start_o  = (state == S_START) ? (N_STAGES'(1) << stage) : '0;
  assign result_valid_o = (state == S_OUT);
  assign busy_o         = (state == S_START) || (state == S_WAIT) || (state == S_OUT);
  assign err_timeout_o  = (state == S_ERR);

  always_comb begin
    cur_stage_o = '0;
    case (state)
      S_START, S_WAIT: cur_stage_o = stage;
      S_OUT:           cur_stage_o = LAST_STAGE;
      default:         cur_stage_o = '0;
    endcase
  end

endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// Bench for cnn_layer_scheduler: directed frames against a cycle-level behavioural model,
// plus literal expectations for latency, ordering, watchdog and counter wrap.
module tb_cnn_layer_scheduler;

  localparam int NS = 8;
  localparam int TO = 16;
  localparam int CW = 2;

  logic          clk;
  logic          reset;
  logic          frame_valid;
  logic          frame_ready;
  logic [NS-1:0] stage_start;
  logic [NS-1:0] stage_done;
  logic          result_valid;
  logic          result_ready;
  logic          busy;
  logic [2:0]    cur_stage;
  logic          err_timeout;
  logic [2:0]    err_stage;
  logic          clear_err;
  logic [CW-1:0] frame_cnt;

  int vectors = 0;
  int errors  = 0;

  cnn_layer_scheduler #(
    .N_STAGES (NS),
    .IDX_W    (3),
    .TIMEOUT_W(20),
    .TIMEOUT  (TO),
    .CNT_W    (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_valid_i (frame_valid),
    .frame_ready_o (frame_ready),
    .stage_start_o (stage_start),
    .stage_done_i  (stage_done),
    .result_valid_o(result_valid),
    .result_ready_i(result_ready),
    .busy_o        (busy),
    .cur_stage_o   (cur_stage),
    .err_timeout_o (err_timeout),
    .err_stage_o   (err_stage),
    .clear_err_i   (clear_err),
    .frame_cnt_o   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 start, 2 wait, 3 result, 4 error.
  int m_mode, m_stg, m_age, m_cnt, m_estg;
  bit m_live, m_ok;
  initial m_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode <= 0; m_stg <= 0; m_age <= 0; m_cnt <= 0; m_estg <= 0;
      m_live <= 1'b0; m_ok <= 1'b1;
    end else if (m_ok) begin
      m_live <= 1'b1;
      case (m_mode)
        0: if (m_live && frame_valid) begin m_mode <= 1; m_stg <= 0; end
        1: begin m_mode <= 2; m_age <= 0; end
        2: begin
          m_age <= m_age + 1;
          if (stage_done[m_stg]) begin
            if (m_stg == NS - 1) m_mode <= 3;
            else begin m_stg <= m_stg + 1; m_mode <= 1; end
          end else if (TO != 0 && m_age + 1 == TO) begin
            m_mode <= 4; m_estg <= m_stg;
          end
        end
        3: if (result_ready) begin m_cnt <= (m_cnt + 1) % (1 << CW); m_mode <= 0; end
        4: if (clear_err) m_mode <= 0;
        default: m_mode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("frame_ready", 32'(frame_ready), 32'(m_mode == 0 && m_live));
      chk("stage_start", 32'(stage_start), (m_mode == 1) ? (32'd1 << m_stg) : 32'd0);
      chk("result_valid", 32'(result_valid), 32'(m_mode == 3));
      chk("busy", 32'(busy), 32'(m_mode >= 1 && m_mode <= 3));
      chk("cur_stage", 32'(cur_stage), (m_mode == 1 || m_mode == 2) ? 32'(m_stg) :
                                       (m_mode == 3) ? 32'(NS - 1) : 32'd0);
      chk("err_timeout", 32'(err_timeout), 32'(m_mode == 4));
      chk("err_stage", 32'(err_stage), 32'(m_estg));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    end
  end

  // mode: 0 plain, 1 stray done[3] in stage 1 + frame_valid during result hold,
  // 2 stage 2 hangs, 3 stage 2 done on the expiry cycle, 4 reset during stage 5 wait
  task automatic run_frame(input int d, input int hold, input int mode);
    int w;
    int dd;
    int rv_cnt;
    time t0;
    w = 0;
    while (!frame_ready && w < 64) begin @(negedge clk); w++; end
    chk("ready_before_frame", 32'(frame_ready), 32'd1);
    frame_valid = 1'b1;
    t0 = $time;
    @(negedge clk);
    frame_valid = 1'b0;
    for (int k = 0; k < NS; k++) begin
      w = 0;
      while (stage_start == '0 && w < 64) begin @(negedge clk); w++; end
      chk("start_order", 32'(stage_start), 32'd1 << k);
      if (stage_start == '0) return;
      if (mode == 4 && k == 5) begin
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (mode == 2 && k == 2) begin
        w = 0;
        while (!err_timeout && w < 64) begin @(negedge clk); w++; end
        chk("wait_cycles_to_err", 32'(w - 1), 32'd16);
        chk("err_stage_lit", 32'(err_stage), 32'd2);
        return;
      end
      dd = (mode == 3 && k == 2) ? TO : d;
      for (int j = 1; j <= dd; j++) begin
        @(negedge clk);
        stage_done = (mode == 1 && k == 1 && j == 2) ? 8'h08 : 8'h00;
      end
      stage_done = 8'(1 << k);
      @(negedge clk);
      stage_done = '0;
      if (mode == 3 && k == 2) chk("start_after_expiry_done", 32'(stage_start), 32'h08);
    end
    chk("result_valid_lit", 32'(result_valid), 32'd1);
    if (d == 1 && mode == 0) chk("accept_to_result", 32'(($time - t0) / 10), 32'd17);
    rv_cnt = 0;
    for (int h = 0; h < hold; h++) begin
      if (result_valid) rv_cnt++;
      frame_valid = (mode == 1);
      @(negedge clk);
    end
    frame_valid = 1'b0;
    if (hold > 0) chk("result_valid_held", 32'(rv_cnt), 32'(hold));
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("result_valid_drop", 32'(result_valid), 32'd0);
    chk("ready_after_result", 32'(frame_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; frame_valid = 1'b0; stage_done = '0;
    result_ready = 1'b0; clear_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("ready_in_reset", 32'(frame_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_release", 32'(frame_ready), 32'd1);
    chk("cnt_after_reset", 32'(frame_cnt), 32'd0);

    run_frame(5, 0, 0);
    chk("cnt_one_frame", 32'(frame_cnt), 32'd1);
    run_frame(5, 10, 1);
    chk("cnt_two_frames", 32'(frame_cnt), 32'd2);

    run_frame(5, 0, 2);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("ready_after_clear", 32'(frame_ready), 32'd1);
    chk("err_stage_kept", 32'(err_stage), 32'd2);

    run_frame(5, 0, 3);
    chk("cnt_after_expiry_frame", 32'(frame_cnt), 32'd3);
    run_frame(1, 0, 0);
    chk("cnt_wrap_to_zero", 32'(frame_cnt), 32'd0);

    run_frame(5, 0, 4);
    @(negedge clk);
    chk("no_start_after_reset", 32'(stage_start), 32'd0);
    chk("cnt_cleared_by_reset", 32'(frame_cnt), 32'd0);
    repeat (5) run_frame(1, 0, 0);
    chk("cnt_wrap_five", 32'(frame_cnt), 32'd1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "bench timeout");
  end

endmodule
